// File: rtl/pll_sup_pkg.sv
// Shared types for the PLL lock supervisor.
// State encoding, loss counter width and a small sizing helper.
package pll_sup_pkg;

   typedef enum logic [2:0] {
      RESET_PLL,
      WAIT_LOCK,
      STABLE,
      RUN,
      FAULT
   } state_t;

   localparam int LOSS_W = 8;

   function automatic int max3(int a, int b, int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with synchronous reset.
// Brings asynchronous level signals into the local clock domain.
module sync_2ff #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock qualifier.
// Holds the processor in reset until PLL lock is stable.
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int RST_PULSE_CYCLES    = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int MAX_RETRIES         = 3
) (
   input  logic                           refclk,
   input  logic                           rst,
   input  logic                           locked_in,
   input  logic                           relock_req,
   output logic                           pll_rst,
   output logic                           sys_rst,
   output logic                           ready,
   output logic                           fault,
   output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt,
   output logic [LOSS_W-1:0]              loss_cnt
);

   localparam int CMAX = max3(RST_PULSE_CYCLES,
                              LOCK_STABLE_CYCLES,
                              LOCK_TIMEOUT_CYCLES);
   localparam int CW = $clog2(CMAX + 1);
   localparam int RW = $clog2(MAX_RETRIES + 1);

   localparam logic [CW-1:0] RST_END = CW'(RST_PULSE_CYCLES - 1);
   localparam logic [CW-1:0] STB_END = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CW-1:0] TO_END  = CW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [RW-1:0] MAX_R   = RW'(MAX_RETRIES);

   state_t            state;
   state_t            state_n;
   logic [CW-1:0]     cnt;
   logic [RW-1:0]     retry_n;
   logic [LOSS_W-1:0] loss_n;
   logic              lock_s;

   sync_2ff #(.W(1)) u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (locked_in),
      .q   (lock_s)
   );

   always_comb begin
      state_n = state;
      retry_n = retry_cnt;
      loss_n  = loss_cnt;
      unique case (state)
         RESET_PLL: begin
            if (cnt == RST_END) state_n = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (lock_s) begin
               state_n = STABLE;
            end else if (cnt == TO_END) begin
               if (retry_cnt == MAX_R) begin
                  state_n = FAULT;
               end else begin
                  retry_n = retry_cnt + RW'(1);
                  state_n = RESET_PLL;
               end
            end
         end
         STABLE: begin
            if (!lock_s) begin
               state_n = WAIT_LOCK;
            end else if (cnt == STB_END) begin
               retry_n = '0;
               state_n = RUN;
            end
         end
         RUN: begin
            // Lock loss takes priority over a software relock request.
            if (!lock_s) begin
               if (loss_cnt != '1) loss_n = loss_cnt + LOSS_W'(1);
               state_n = RESET_PLL;
            end else if (relock_req) begin
               state_n = RESET_PLL;
            end
         end
         FAULT: begin
            if (relock_req) begin
               retry_n = '0;
               state_n = RESET_PLL;
            end
         end
         default: state_n = RESET_PLL;
      endcase
   end

   // Outputs decode from the next state so they move with the state.
   always_ff @(posedge refclk) begin
      if (rst) begin
         state     <= RESET_PLL;
         cnt       <= '0;
         retry_cnt <= '0;
         loss_cnt  <= '0;
         pll_rst   <= 1'b1;
         sys_rst   <= 1'b1;
         ready     <= 1'b0;
         fault     <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= (state_n != state) ? '0 : cnt + CW'(1);
         retry_cnt <= retry_n;
         loss_cnt  <= loss_n;
         pll_rst   <= (state_n == RESET_PLL) || (state_n == FAULT);
         sys_rst   <= (state_n != RUN);
         ready     <= (state_n == RUN);
         fault     <= (state_n == FAULT);
      end
   end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Lock supervisor for the board PLL, on the other end of the PLL's `rst`/`locked` interface. It drives the PLL reset, watches the asynchronous `locked` indication and qualifies lock as stable. It then releases the processor's system reset and re-sequences the PLL on timeout, loss of lock or software request. It sits between the PLL instance and the single-cycle processor reset tree and runs on the 50 MHz reference clock.

## Interface
Parameters:
- `RST_PULSE_CYCLES`, default 16: width of the PLL reset pulse, in refclk cycles (≥2).
- `LOCK_STABLE_CYCLES`, default 1024: consecutive synchronized-lock cycles required before system reset is released (≥2).
- `LOCK_TIMEOUT_CYCLES`, default 65536: maximum wait for lock after the PLL reset ends.
- `MAX_RETRIES`, default 3: timeouts tolerated before entering FAULT (≥1).

Ports:
- `refclk`, in, 1: sole clock (50 MHz reference).
- `rst`, in, 1: synchronous, active-high reset.
- `locked_in`, in, 1: PLL `locked`, asynchronous to refclk.
- `relock_req`, in, 1: single-cycle request to re-sequence the PLL.
- `pll_rst`, out, 1: reset to the PLL, active high.
- `sys_rst`, out, 1: system reset to the processor, active high.
- `ready`, out, 1: high in RUN only.
- `fault`, out, 1: high in FAULT only.
- `retry_cnt`, out, $clog2(MAX_RETRIES+1): timeouts since the last successful lock.
- `loss_cnt`, out, 8: saturating count of lock losses in RUN.

## Operation
- `locked_in` passes through a 2-flop synchronizer to give `lock_s`. FSM decisions use only `lock_s`.
- One shared cycle counter `cnt`, wide enough for the largest parameter. It clears on every state change.
- All outputs are registered and decoded from state (Moore). They change on the same edge as the state.
- Reset values: state = RESET_PLL, `pll_rst` = 1, `sys_rst` = 1, `ready` = 0, `fault` = 0, `retry_cnt` = 0, `loss_cnt` = 0, `cnt` = 0, synchronizer flops = 0.
- RESET_PLL: `pll_rst` = 1, `sys_rst` = 1. Go to WAIT_LOCK when `cnt` = RST_PULSE_CYCLES-1.
- WAIT_LOCK: `pll_rst` = 0, `sys_rst` = 1.
  - `lock_s` = 1: go to STABLE.
  - Otherwise, at `cnt` = LOCK_TIMEOUT_CYCLES-1: go to FAULT if `retry_cnt` = MAX_RETRIES; else increment `retry_cnt` and go to RESET_PLL.
- STABLE: `sys_rst` = 1.
  - `lock_s` = 0: go back to WAIT_LOCK with `cnt` cleared. The timeout restarts.
  - `cnt` = LOCK_STABLE_CYCLES-1 with `lock_s` = 1: go to RUN and clear `retry_cnt`.
- RUN: `sys_rst` = 0, `ready` = 1.
  - `lock_s` = 0: increment `loss_cnt` (saturates at 255) and go to RESET_PLL.
  - `relock_req` = 1: go to RESET_PLL without changing `loss_cnt`.
- FAULT: `pll_rst` = 1, `sys_rst` = 1, `fault` = 1. Held until `rst`, or until `relock_req`, which clears `retry_cnt` and goes to RESET_PLL.
- Simultaneous events:
  - `relock_req` in RESET_PLL, WAIT_LOCK or STABLE is ignored.
  - In RUN, if lock loss and `relock_req` occur together, lock loss wins and `loss_cnt` increments.
  - `rst` overrides everything on any edge, including mid-sequence. Counters and the synchronizer clear.

## Timing
- Synchronizer latency is 2 edges.
  - If edge k is the first to sample `locked_in` = 1 and lock holds, STABLE is entered at edge k+2.
  - `sys_rst` = 0 and `ready` = 1 after edge k+2+LOCK_STABLE_CYCLES.
- Lock loss in RUN: if edge j first samples `locked_in` = 0, then `sys_rst` = 1 and `pll_rst` = 1 after edge j+2.
- `pll_rst` pulse: exactly RST_PULSE_CYCLES cycles per RESET_PLL entry.
- A glitch on `locked_in` shorter than one cycle may or may not be captured. If captured, it is treated as a real event.
- `sys_rst` never deasserts while `pll_rst` = 1.

## Structure
- Package `pll_sup_pkg`: the state enum (RESET_PLL, WAIT_LOCK, STABLE, RUN, FAULT) and the `loss_cnt` width constant.
- One sub-module, `sync_2ff`: a generic 2-flop synchronizer with a synchronous reset. It is reused later for other asynchronous inputs.

## Test plan
All scenarios use RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
1. Assert `rst`, release it, then raise `locked_in` 10 cycles later -> `pll_rst` high for exactly 4 cycles; `sys_rst` low 10 edges after the first high sample; `ready` = 1; `retry_cnt` = 0.
2. Hold `locked_in` = 0 throughout -> 3 RESET_PLL pulses of 4 cycles, 32 cycles of waiting between them, `retry_cnt` going 1 then 2, then FAULT with `fault` = 1 and `pll_rst` = 1. A `relock_req` pulse then gives a new 4-cycle pulse with `retry_cnt` = 0.
3. In STABLE, drop `locked_in` for 3 cycles after 5 good cycles, then restore it -> stays in WAIT_LOCK/STABLE; `sys_rst` low only after 8 consecutive good `lock_s` cycles.
4. In RUN, drop `locked_in` -> `sys_rst` = 1 two edges later, `loss_cnt` = 1, 4-cycle `pll_rst` pulse, then normal relock.
5. In RUN, drive `relock_req` and `locked_in` = 0 in the same cycle, and separately drive `relock_req` alone -> `loss_cnt` increments only for the lock-loss case; both re-sequence.
6. Assert `rst` mid-WAIT_LOCK with `retry_cnt` = 1 -> all outputs return to reset values on the next edge and `retry_cnt` = 0.
